// File: rtl/vga_pkg.sv
// ============================================================================
// Module      : vga_pkg
// Description : 640x480@60 Hz timing constants and coordinate helpers.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package vga_pkg;

    localparam int COORD_W  = 10;
    localparam int CE_DIV   = 4;

    localparam int H_VIS    = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;

    localparam int V_VIS    = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;

    localparam int H_SYNC_START = H_VIS + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_VIS + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    localparam logic SYNC_POL = 1'b0;

    typedef logic [COORD_W-1:0] coord_t;

    function automatic logic in_window(input coord_t c, input int lo, input int hi);
        return (int'(c) >= lo) && (int'(c) <= hi);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_sync_gen_if.sv
// ============================================================================
// Module      : vga_sync_gen_if
// Description : Timing bundle from the sync generator to the pixel renderer.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface vga_sync_gen_if;
    import vga_pkg::*;

    logic   pix_ce;
    coord_t hcount;
    coord_t vcount;
    logic   hsync;
    logic   vsync;
    logic   video_on;
    logic   line_tick;
    logic   frame_tick;

    modport master (
        output pix_ce, hcount, vcount, hsync, vsync,
               video_on, line_tick, frame_tick
    );

    modport slave (
        input  pix_ce, hcount, vcount, hsync, vsync,
               video_on, line_tick, frame_tick
    );

endinterface

`default_nettype wire

// File: rtl/vga_sync_gen_pix_ce_gen.sv
// ============================================================================
// Module      : pix_ce_gen
// Description : Divide-by-CE_DIV pixel enable; ce_en is the raw terminal
//               count, pix_ce its registered one-cycle pulse.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pix_ce_gen #(
    parameter int CE_DIV = 4
) (
    input  logic mclk,
    input  logic clr,
    output logic ce_en,
    output logic pix_ce
);

    localparam int CNT_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

    logic [CNT_W-1:0] ce_cnt_q;
    logic [CNT_W-1:0] ce_cnt_d;
    logic             pix_ce_q;
    logic             pix_ce_d;

    always_comb begin
        ce_en    = (ce_cnt_q == CNT_W'(CE_DIV - 1));
        ce_cnt_d = ce_en ? '0 : ce_cnt_q + CNT_W'(1);
        pix_ce_d = ce_en;
    end

    always_ff @(posedge mclk) begin
        if (!clr) begin
            ce_cnt_q <= '0;
            pix_ce_q <= 1'b0;
        end else begin
            ce_cnt_q <= ce_cnt_d;
            pix_ce_q <= pix_ce_d;
        end
    end

    assign pix_ce = pix_ce_q;

endmodule

`default_nettype wire

// File: rtl/vga_sync_gen.sv
// ============================================================================
// Module      : vga_sync_gen
// Description : VGA raster timing: pixel/line counters, syncs, video-active
//               flag and line/frame ticks, all on the mclk domain.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int   CE_DIV   = vga_pkg::CE_DIV,
    parameter int   H_VIS    = vga_pkg::H_VIS,
    parameter int   H_FP     = vga_pkg::H_FP,
    parameter int   H_SYNC   = vga_pkg::H_SYNC,
    parameter int   H_BP     = vga_pkg::H_BP,
    parameter int   V_VIS    = vga_pkg::V_VIS,
    parameter int   V_FP     = vga_pkg::V_FP,
    parameter int   V_SYNC   = vga_pkg::V_SYNC,
    parameter int   V_BP     = vga_pkg::V_BP,
    parameter logic SYNC_POL = vga_pkg::SYNC_POL
) (
    input  logic           mclk,
    input  logic           clr,
    vga_sync_gen_if.master vga
);

    localparam int H_TOT   = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT   = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int H_SS    = H_VIS + H_FP;
    localparam int H_SE    = H_SS + H_SYNC - 1;
    localparam int V_SS    = V_VIS + V_FP;
    localparam int V_SE    = V_SS + V_SYNC - 1;

    logic   ce_en;
    logic   pix_ce;
    logic   h_wrap;
    logic   v_wrap;

    coord_t hcount_q,     hcount_d;
    coord_t vcount_q,     vcount_d;
    logic   hsync_q,      hsync_d;
    logic   vsync_q,      vsync_d;
    logic   video_on_q,   video_on_d;
    logic   line_tick_q,  line_tick_d;
    logic   frame_tick_q, frame_tick_d;

    pix_ce_gen #(
        .CE_DIV (CE_DIV)
    ) u_pix_ce_gen (
        .mclk   (mclk),
        .clr    (clr),
        .ce_en  (ce_en),
        .pix_ce (pix_ce)
    );

    // Syncs and video_on decode the next-state counters so they line up
    // with the hcount/vcount visible in the same cycle.
    always_comb begin
        h_wrap       = (hcount_q == COORD_W'(H_TOT - 1));
        v_wrap       = (vcount_q == COORD_W'(V_TOT - 1));
        hcount_d     = hcount_q;
        vcount_d     = vcount_q;
        hsync_d      = hsync_q;
        vsync_d      = vsync_q;
        video_on_d   = video_on_q;
        line_tick_d  = 1'b0;
        frame_tick_d = 1'b0;
        if (ce_en) begin
            hcount_d = h_wrap ? '0 : hcount_q + COORD_W'(1);
            if (h_wrap) begin
                vcount_d = v_wrap ? '0 : vcount_q + COORD_W'(1);
            end
            line_tick_d  = h_wrap;
            frame_tick_d = h_wrap && v_wrap;
            hsync_d      = in_window(hcount_d, H_SS, H_SE) ? SYNC_POL : ~SYNC_POL;
            vsync_d      = in_window(vcount_d, V_SS, V_SE) ? SYNC_POL : ~SYNC_POL;
            video_on_d   = (hcount_d < COORD_W'(H_VIS)) && (vcount_d < COORD_W'(V_VIS));
        end
    end

    always_ff @(posedge mclk) begin
        if (!clr) begin
            hcount_q     <= '0;
            vcount_q     <= '0;
            hsync_q      <= ~SYNC_POL;
            vsync_q      <= ~SYNC_POL;
            video_on_q   <= 1'b0;
            line_tick_q  <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            hcount_q     <= hcount_d;
            vcount_q     <= vcount_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            video_on_q   <= video_on_d;
            line_tick_q  <= line_tick_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign vga.pix_ce     = pix_ce;
    assign vga.hcount     = hcount_q;
    assign vga.vcount     = vcount_q;
    assign vga.hsync      = hsync_q;
    assign vga.vsync      = vsync_q;
    assign vga.video_on   = video_on_q;
    assign vga.line_tick  = line_tick_q;
    assign vga.frame_tick = frame_tick_q;

endmodule

`default_nettype wire
